// File: rtl/ofdm_pkg.sv
// Shared constants and the bin classification used by the OFDM subcarrier mapper.
package ofdm_pkg;

  localparam int NFFT    = 64;
  localparam int N_DATA  = 48;
  localparam int N_PILOT = 4;
  localparam int BIN_W   = 6;

  // Pilot bins, lowest index in the low field; PILOT_NEG marks the -1 pilot (bin 21).
  localparam logic [N_PILOT*BIN_W-1:0] PILOT_IDX = {6'd57, 6'd43, 6'd21, 6'd7};
  localparam logic [N_PILOT-1:0]       PILOT_NEG = 4'b0010;

  typedef enum logic [1:0] {
    BinNull,
    BinPilot,
    BinData
  } bin_type_e;

  // Classify an FFT bin: DC and the guard band are null, four pilots, the rest carry data.
  function automatic bin_type_e bin_type(input logic [BIN_W-1:0] k);
    bin_type_e t;
    t = BinData;
    if (k == '0 || (k >= 6'd27 && k <= 6'd37)) begin
      t = BinNull;
    end
    for (int i = 0; i < N_PILOT; i++) begin
      if (PILOT_IDX[i*BIN_W +: BIN_W] == k) begin
        t = BinPilot;
      end
    end
    return t;
  endfunction

  // True when bin k is a pilot carrying -1.
  function automatic logic pilot_neg(input logic [BIN_W-1:0] k);
    logic neg;
    neg = 1'b0;
    for (int i = 0; i < N_PILOT; i++) begin
      if (PILOT_IDX[i*BIN_W +: BIN_W] == k) begin
        neg = PILOT_NEG[i];
      end
    end
    return neg;
  endfunction

endpackage

// File: rtl/ofdm_subcarrier_mapper.sv
// Maps 48 data symbols per OFDM symbol onto a 64-bin frame (nulls, pilots, data) for the IFFT.
module ofdm_subcarrier_mapper
  import ofdm_pkg::*;
#(
  parameter int unsigned              DATA_W    = 12,
  parameter logic signed [DATA_W-1:0] PILOT_AMP = 12'sd1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [2*DATA_W-1:0] s_axis_sym_tdata,
  input  logic                s_axis_sym_tvalid,
  input  logic                s_axis_sym_tlast,
  output logic                s_axis_sym_tready,
  output logic [31:0]         m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  output logic                m_axis_data_tlast,
  input  logic                m_axis_data_tready,
  output logic                event_frame_started,
  output logic                event_tlast_unexpected,
  output logic                event_tlast_missing
);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  localparam logic [BIN_W-1:0] LastBin  = BIN_W'(NFFT - 1);
  localparam logic [BIN_W-1:0] LastData = BIN_W'(N_DATA - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   k_q, k_d;
  logic [BIN_W-1:0]   d_q, d_d;
  logic [31:0]        tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               started_q, started_d;
  logic               unexp_q, unexp_d;
  logic               miss_q, miss_d;

  logic               load_en;
  logic               load_bin;
  logic               sym_accept;
  bin_type_e          k_type;
  logic signed [DATA_W-1:0] sym_re, sym_im, pilot_re;
  logic [31:0]        data_word, pilot_word;

  assign load_en    = !tvalid_q | m_axis_data_tready;
  assign k_type     = bin_type(k_q);
  // Only data bins pull from the input; null/pilot bins never consume a symbol.
  assign s_axis_sym_tready = load_en & (state_q == StRun | state_q == StIdle) &
                             (k_type == BinData);
  assign sym_accept = s_axis_sym_tvalid & s_axis_sym_tready;

  assign sym_re     = s_axis_sym_tdata[DATA_W-1:0];
  assign sym_im     = s_axis_sym_tdata[2*DATA_W-1:DATA_W];
  assign pilot_re   = pilot_neg(k_q) ? -PILOT_AMP : PILOT_AMP;
  // Each component sign-extended to 16 bits for the IFFT input format.
  assign data_word  = {16'(sym_im), 16'(sym_re)};
  assign pilot_word = {16'd0, 16'(pilot_re)};

  // Next-state: frame sequencing, output register load and framing checks.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    d_d       = d_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    started_d = 1'b0;
    unexp_d   = 1'b0;
    miss_d    = 1'b0;
    load_bin  = 1'b0;

    if (load_en) begin
      unique case (state_q)
        StIdle: begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          // Bin 0 is null, so a pending symbol only triggers the frame; it is not consumed.
          if (s_axis_sym_tvalid) begin
            tdata_d   = '0;
            tvalid_d  = 1'b1;
            started_d = 1'b1;
            k_d       = BIN_W'(1);
            d_d       = '0;
            state_d   = StRun;
          end
        end
        StRun: begin
          load_bin = (k_type != BinData) | s_axis_sym_tvalid;
          tvalid_d = load_bin;
          if (load_bin) begin
            unique case (k_type)
              BinData:  tdata_d = data_word;
              BinPilot: tdata_d = pilot_word;
              default:  tdata_d = '0;
            endcase
            tlast_d = (k_q == LastBin);
            k_d     = k_q + 1'b1;
            if (k_q == LastBin) begin
              state_d = StIdle;
            end
          end else begin
            tlast_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Framing is fixed by the bin counter; tlast is only checked, never used to resync.
    if (sym_accept) begin
      d_d     = (d_q == LastData) ? '0 : d_q + 1'b1;
      unexp_d = s_axis_sym_tlast & (d_q != LastData);
      miss_d  = !s_axis_sym_tlast & (d_q == LastData);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      k_q       <= '0;
      d_q       <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      started_q <= 1'b0;
      unexp_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      d_q       <= d_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      started_q <= started_d;
      unexp_q   <= unexp_d;
      miss_q    <= miss_d;
    end
  end

  assign m_axis_data_tdata      = tdata_q;
  assign m_axis_data_tvalid     = tvalid_q;
  assign m_axis_data_tlast      = tlast_q;
  assign event_frame_started    = started_q;
  assign event_tlast_unexpected = unexp_q;
  assign event_tlast_missing    = miss_q;

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Directed bench for ofdm_subcarrier_mapper.
module tb_ofdm_subcarrier_mapper;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        ev_start, ev_unexp, ev_miss;

  int n_cmp = 0;
  int n_err = 0;

  bit rand_ready = 1'b0;
  bit ready_level = 1'b1;
  bit abort = 1'b0;

  logic [23:0] tx_syms[$];
  bit          tx_last[$];
  logic [31:0] out_data[$];
  bit          out_last[$];
  int          out_cyc[$];
  int          started_at[$];
  int          unexp_at[$];
  int          miss_at[$];
  int          in_cnt, stall_viol, tvalid_hi, tready_hi, ev_cnt, cyc;
  bit          stalled_prev;
  logic [31:0] prev_data;
  logic        prev_last;

  ofdm_subcarrier_mapper dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_sym_tdata       (s_tdata),
    .s_axis_sym_tvalid      (s_tvalid),
    .s_axis_sym_tlast       (s_tlast),
    .s_axis_sym_tready      (s_tready),
    .m_axis_data_tdata      (m_tdata),
    .m_axis_data_tvalid     (m_tvalid),
    .m_axis_data_tlast      (m_tlast),
    .m_axis_data_tready     (m_tready),
    .event_frame_started    (ev_start),
    .event_tlast_unexpected (ev_unexp),
    .event_tlast_missing    (ev_miss)
  );

  always #5 aclk = ~aclk;

  // Downstream ready: fixed level or a coin flip each cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    cyc = 0;
    stalled_prev = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (ev_start === 1'b1) started_at.push_back(out_data.size());
      if (ev_unexp === 1'b1) unexp_at.push_back(in_cnt - 1);
      if (ev_miss === 1'b1) miss_at.push_back(in_cnt - 1);
      if ((ev_start | ev_unexp | ev_miss) === 1'b1) ev_cnt++;
      if (m_tvalid === 1'b1) tvalid_hi++;
      if (s_tready === 1'b1) tready_hi++;
      if (stalled_prev && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
        stall_viol++;
      stalled_prev = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (s_tvalid && s_tready === 1'b1) in_cnt++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    started_at.delete();
    unexp_at.delete();
    miss_at.delete();
    in_cnt = 0;
    stall_viol = 0;
    tvalid_hi = 0;
    tready_hi = 0;
    ev_cnt = 0;
    stalled_prev = 1'b0;
  endtask

  // Hand-derived bin layout: -1 null, -2 pilot +1, -3 pilot -1, else data symbol index.
  function automatic int data_index(input int k);
    if (k == 0 || (k >= 27 && k <= 37)) return -1;
    if (k == 7 || k == 43 || k == 57) return -2;
    if (k == 21) return -3;
    if (k < 7) return k - 1;
    if (k < 21) return k - 2;
    if (k < 27) return k - 3;
    if (k < 43) return k - 14;
    if (k < 57) return k - 15;
    return k - 16;
  endfunction

  function automatic logic [31:0] exp_word(input int b);
    int f, d;
    logic [23:0] s;
    f = b / 64;
    d = data_index(b % 64);
    if (d == -1) return 32'h0000_0000;
    if (d == -2) return 32'h0000_0400;
    if (d == -3) return 32'h0000_fc00;
    s = tx_syms[f * 48 + d];
    return {{4{s[23]}}, s[23:12], {4{s[11]}}, s[11:0]};
  endfunction

  // Drive tx_syms[first +: count], waiting for each handshake.
  task automatic send_syms(input int first, input int count, input bit gaps);
    int w;
    for (int i = first; i < first + count && !abort; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = tx_syms[i];
      s_tlast  = tx_last[i];
      w = 0;
      @(negedge aclk);
      while (s_tready !== 1'b1 && !abort && w < 2000) begin
        @(negedge aclk);
        w++;
      end
      if (w >= 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: symbol %0d not accepted within 2000 cycles", i);
        abort = 1'b1;
      end
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (out_data.size() < n && t < budget) begin
      @(posedge aclk);
      t++;
    end
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    #1 aresetn = 1'b0;
    #3;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (m_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    n_cmp++;
    if ({ev_start, ev_unexp, ev_miss} !== 3'b000) begin
      n_err++; $display("FAIL reset_events: got %b want 000", {ev_start, ev_unexp, ev_miss});
    end
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL post_reset_tready: got %b want 0", s_tready); end
  endtask

  task automatic test_frame_basic();
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    for (int n = 0; n < 48; n++) begin
      tx_syms.push_back({12'(-n), 12'(n)});
      tx_last.push_back(n == 47);
    end
    send_syms(0, 48, 1'b0);
    wait_beats(64, 300);
    n_cmp++; if (out_data.size() != 64) begin n_err++; $display("FAIL basic_count: got %0d want 64", out_data.size()); end
    for (int b = 0; b < 64; b++) begin
      n_cmp++;
      if (out_data[b] !== exp_word(b) || out_last[b] !== (b == 63)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got %h/%b want %h/%b", b, out_data[b], out_last[b], exp_word(b), b == 63);
      end
    end
    n_cmp++; if (out_data[7] !== 32'h0000_0400) begin n_err++; $display("FAIL basic_bin7: got %h want 00000400", out_data[7]); end
    n_cmp++; if (out_data[21] !== 32'h0000_fc00) begin n_err++; $display("FAIL basic_bin21: got %h want 0000fc00", out_data[21]); end
    // Bin 38 carries the 25th symbol (re=24, im=-24).
    n_cmp++; if (out_data[38] !== 32'hffe8_0018) begin n_err++; $display("FAIL basic_bin38: got %h want ffe80018", out_data[38]); end
    n_cmp++; if (out_data[63] !== 32'hffd1_002f) begin n_err++; $display("FAIL basic_bin63: got %h want ffd1002f", out_data[63]); end
    n_cmp++;
    if (!(started_at.size() == 1 && started_at[0] == 0)) begin
      n_err++; $display("FAIL basic_started: got %0d pulses want 1 at beat 0", started_at.size());
    end
    n_cmp++;
    if (unexp_at.size() != 0 || miss_at.size() != 0) begin
      n_err++; $display("FAIL basic_errors: got unexp=%0d miss=%0d want 0/0", unexp_at.size(), miss_at.size());
    end
  endtask

  task automatic test_random_stall();
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    for (int n = 0; n < 48; n++) begin
      tx_syms.push_back(24'($urandom));
      tx_last.push_back(n == 47);
    end
    rand_ready = 1'b1;
    send_syms(0, 48, 1'b1);
    wait_beats(64, 3000);
    rand_ready = 1'b0;
    ready_level = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (out_data.size() != 64) begin n_err++; $display("FAIL stall_count: got %0d want 64", out_data.size()); end
    for (int b = 0; b < 64; b++) begin
      n_cmp++;
      if (out_data[b] !== exp_word(b) || out_last[b] !== (b == 63)) begin
        n_err++;
        $display("FAIL stall_beat%0d: got %h/%b want %h/%b", b, out_data[b], out_last[b], exp_word(b), b == 63);
      end
    end
    n_cmp++; if (stall_viol != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
    n_cmp++; if (in_cnt != 48) begin n_err++; $display("FAIL stall_consumed: got %0d want 48", in_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    for (int n = 0; n < 144; n++) begin
      tx_syms.push_back(24'($urandom));
      tx_last.push_back((n % 48) == 47);
    end
    send_syms(0, 144, 1'b0);
    wait_beats(192, 600);
    n_cmp++; if (out_data.size() != 192) begin n_err++; $display("FAIL b2b_count: got %0d want 192", out_data.size()); end
    for (int b = 0; b < 192; b++) begin
      n_cmp++;
      if (out_data[b] !== exp_word(b) || out_last[b] !== ((b % 64) == 63)) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", b, out_data[b], out_last[b], exp_word(b), (b % 64) == 63);
      end
    end
    n_cmp++;
    if (out_cyc[191] - out_cyc[0] != 191) begin
      n_err++; $display("FAIL b2b_bubbles: got span %0d want 191", out_cyc[191] - out_cyc[0]);
    end
    n_cmp++;
    if (!(started_at.size() == 3 && started_at[0] == 0 && started_at[1] == 64 && started_at[2] == 128)) begin
      n_err++; $display("FAIL b2b_started: got %0d pulses want 3 at 0/64/128", started_at.size());
    end
  endtask

  task automatic test_framing_errors();
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    for (int n = 0; n < 96; n++) begin
      tx_syms.push_back({12'(n + 200), 12'(-3 * n)});
      tx_last.push_back(n == 30 || n == 47);
    end
    send_syms(0, 96, 1'b0);
    wait_beats(128, 500);
    n_cmp++; if (out_data.size() != 128) begin n_err++; $display("FAIL frm_count: got %0d want 128", out_data.size()); end
    for (int b = 0; b < 128; b++) begin
      n_cmp++;
      if (out_data[b] !== exp_word(b) || out_last[b] !== ((b % 64) == 63)) begin
        n_err++;
        $display("FAIL frm_beat%0d: got %h/%b want %h/%b", b, out_data[b], out_last[b], exp_word(b), (b % 64) == 63);
      end
    end
    n_cmp++;
    if (!(unexp_at.size() == 1 && unexp_at[0] == 30)) begin
      n_err++; $display("FAIL frm_unexpected: got %0d pulses want 1 at symbol 30", unexp_at.size());
    end
    n_cmp++;
    if (!(miss_at.size() == 1 && miss_at[0] == 95)) begin
      n_err++; $display("FAIL frm_missing: got %0d pulses want 1 at symbol 95", miss_at.size());
    end
  endtask

  task automatic test_idle();
    clear_mon();
    s_tvalid = 1'b0;
    rand_ready = 1'b1;
    repeat (100) @(posedge aclk);
    #1;
    rand_ready = 1'b0;
    n_cmp++; if (tvalid_hi != 0) begin n_err++; $display("FAIL idle_tvalid: got %0d cycles want 0", tvalid_hi); end
    n_cmp++; if (tready_hi != 0) begin n_err++; $display("FAIL idle_tready: got %0d cycles want 0", tready_hi); end
    n_cmp++; if (ev_cnt != 0) begin n_err++; $display("FAIL idle_events: got %0d pulses want 0", ev_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    ready_level = 1'b1;
    for (int n = 0; n < 48; n++) begin
      tx_syms.push_back(24'($urandom));
      tx_last.push_back(n == 47);
    end
    abort = 1'b0;
    fork
      send_syms(0, 48, 1'b0);
      begin
        int t;
        t = 0;
        while (out_data.size() < 40 && t < 500) begin
          @(negedge aclk);
          t++;
        end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_tvalid: got %b want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_mid_tlast: got %b want 0", m_tlast); end
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_mid_tready: got %b want 0", s_tready); end
        abort = 1'b1;
      end
    join
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    abort = 1'b0;
    @(posedge aclk);
    #1;
    clear_mon();
    tx_syms.delete();
    tx_last.delete();
    for (int n = 0; n < 48; n++) begin
      tx_syms.push_back({12'(n - 50), 12'(n + 100)});
      tx_last.push_back(n == 47);
    end
    send_syms(0, 48, 1'b0);
    wait_beats(64, 300);
    n_cmp++; if (out_data.size() != 64) begin n_err++; $display("FAIL rst_new_count: got %0d want 64", out_data.size()); end
    for (int b = 0; b < 64; b++) begin
      n_cmp++;
      if (out_data[b] !== exp_word(b) || out_last[b] !== (b == 63)) begin
        n_err++;
        $display("FAIL rst_new_beat%0d: got %h/%b want %h/%b", b, out_data[b], out_last[b], exp_word(b), b == 63);
      end
    end
    // First data bin after the abandoned frame holds the fresh symbol 0 (re=100, im=-50).
    n_cmp++; if (out_data[1] !== 32'hffce_0064) begin n_err++; $display("FAIL rst_new_bin1: got %h want ffce0064", out_data[1]); end
    n_cmp++;
    if (!(started_at.size() == 1 && started_at[0] == 0)) begin
      n_err++; $display("FAIL rst_new_started: got %0d pulses want 1 at beat 0", started_at.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_random_stall();
    test_back_to_back();
    test_framing_errors();
    test_idle();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
